// File: rtl/dmem_arbiter.sv
// Round-robin arbiter between two requesters for a byte-wide data RAM.
// Each granted access is serialised MSB-first into one RAM byte per cycle, then answered with one response pulse.
module dmem_arbiter #(
  parameter int WIDTH   = 32,
  parameter int ADDR_W  = 17,
  parameter int RR_INIT = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [1:0]             req_we,
  input  logic [1:0][2:0]        req_size,
  input  logic [1:0][WIDTH-1:0]  req_addr,
  input  logic [1:0][WIDTH-1:0]  req_wdata,
  output logic [1:0]             rsp_valid,
  output logic [WIDTH-1:0]       rsp_rdata,
  output logic                   rsp_err,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic                   mem_we,
  output logic [7:0]             mem_wdata,
  input  logic [7:0]             mem_rdata,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, RESP = 2'd2} state_t;

  function automatic logic size_ok(input logic [2:0] size);
    return (size >= 3'b001) && (size <= 3'b101);
  endfunction

  // Index of the last byte in the access: W 3, H 1, B 0.
  function automatic logic [1:0] size_last(input logic [2:0] size);
    case (size)
      3'b001:        return 2'd3;
      3'b010, 3'b100: return 2'd1;
      default:       return 2'd0;
    endcase
  endfunction

  function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] idx);
    return w[{idx, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] d, input logic [2:0] size);
    case (size)
      3'b010:  return {{16{d[15]}}, d[15:0]};
      3'b100:  return {16'h0000, d[15:0]};
      3'b011:  return {{24{d[7]}}, d[7:0]};
      3'b101:  return {24'h000000, d[7:0]};
      default: return d;
    endcase
  endfunction

  state_t            state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              rr_q, rr_d;
  logic              we_q, we_d;
  logic [2:0]        size_q, size_d;
  logic [1:0]        last_q, last_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       data_q, data_d;
  logic [1:0]        rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              busy_q, busy_d;
  logic              gnt;

  // Only the low ADDR_W address bits reach the RAM; the top load byte shifts out unused.
  logic unused_bits;
  assign unused_bits = ^{req_addr[0][WIDTH-1:ADDR_W], req_addr[1][WIDTH-1:ADDR_W], data_q[31:24]};

  assign gnt = (req_valid == 2'b11) ? rr_q : req_valid[1];

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    rr_d        = rr_q;
    we_d        = we_q;
    size_d      = size_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    data_d      = data_q;
    rsp_valid_d = 2'b00;
    rsp_rdata_d = 32'h0;
    rsp_err_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = 8'h00;
    req_ready   = 2'b00;

    case (state_q)
      IDLE: begin
        if (req_valid != 2'b00) begin
          req_ready = gnt ? 2'b10 : 2'b01;
          gnt_d     = gnt;
          rr_d      = ~gnt;
          we_d      = req_we[gnt];
          size_d    = req_size[gnt];
          last_d    = size_last(req_size[gnt]);
          addr_d    = req_addr[gnt][ADDR_W-1:0];
          wdata_d   = req_wdata[gnt];
          cnt_d     = 2'd0;
          data_d    = 32'h0;
          if (size_ok(req_size[gnt])) begin
            // First byte is presented on the RAM port right after the accept edge.
            state_d     = XFER;
            mem_we_d    = req_we[gnt];
            mem_addr_d  = req_addr[gnt][ADDR_W-1:0];
            mem_wdata_d = req_we[gnt] ? pick_byte(req_wdata[gnt], size_last(req_size[gnt])) : 8'h00;
          end else begin
            state_d     = RESP;
            rsp_valid_d = gnt ? 2'b10 : 2'b01;
            rsp_err_d   = 1'b1;
          end
        end
      end
      XFER: begin
        if (!we_q) begin
          data_d = {data_q[23:0], mem_rdata};
        end
        if (cnt_q == last_q) begin
          state_d     = RESP;
          rsp_valid_d = gnt_q ? 2'b10 : 2'b01;
          rsp_rdata_d = we_q ? 32'h0 : extend(data_d, size_q);
        end else begin
          cnt_d       = cnt_q + 2'd1;
          mem_we_d    = we_q;
          mem_addr_d  = addr_q + ADDR_W'(cnt_d);
          mem_wdata_d = we_q ? pick_byte(wdata_q, last_q - cnt_d) : 8'h00;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= 1'b0;
      rr_q        <= (RR_INIT != 0);
      we_q        <= 1'b0;
      size_q      <= 3'b000;
      last_q      <= 2'd0;
      cnt_q       <= 2'd0;
      addr_q      <= '0;
      wdata_q     <= 32'h0;
      data_q      <= 32'h0;
      rsp_valid_q <= 2'b00;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'h00;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      rr_q        <= rr_d;
      we_q        <= we_d;
      size_q      <= size_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      data_q      <= data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a transaction-level model predicts each response at accept time,
// and an independent monitor checks responses, latency and idle-port behaviour.
module tb_dmem_arbiter;
  localparam int ADDR_W = 17;
  localparam int MEM_SZ = 1 << ADDR_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [1:0]        req_valid, req_ready, req_we, rsp_valid;
  logic [1:0][2:0]   req_size;
  logic [1:0][31:0]  req_addr, req_wdata;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_wdata, mem_rdata;
  logic              busy;

  logic [7:0] ram [MEM_SZ];
  logic [7:0] ref_ram [MEM_SZ];

  dmem_arbiter #(.WIDTH(32), .ADDR_W(ADDR_W), .RR_INIT(0)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  assign mem_rdata = ram[mem_addr];
  always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_wdata;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        has_k;
    logic [31:0] k;
  } req_t;

  typedef struct {
    int          side;
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  req_t q0[$];
  req_t q1[$];
  req_t cur[2];
  exp_t exp_q[$];
  exp_t mon_e;
  int   grant_log[$];
  logic rr_m;
  logic gap_en, wd_en;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_req(input int s, input logic we, input logic [2:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic has_k, input logic [31:0] k);
    req_t r;
    r.we = we; r.size = size; r.addr = addr; r.wdata = wdata; r.has_k = has_k; r.k = k;
    if (s == 0) q0.push_back(r); else q1.push_back(r);
  endtask

  // Transaction-level model: whole access applied to ref_ram the moment it is accepted.
  task automatic model_accept(input int s, input logic both);
    req_t r;
    exp_t e;
    int n;
    logic [31:0] v;
    r = cur[s];
    if (both) chk("rr_grant", 32'(s), {31'h0, rr_m});
    rr_m = (s == 0);
    grant_log.push_back(s);
    case (r.size)
      3'd1:       n = 4;
      3'd2, 3'd4: n = 2;
      3'd3, 3'd5: n = 1;
      default:    n = 0;
    endcase
    v = 32'h0;
    if (n != 0 && r.we) begin
      for (int k = 0; k < n; k++)
        ref_ram[int'((r.addr + 32'(k)) & 32'(MEM_SZ - 1))] = 8'(r.wdata >> (8 * (n - 1 - k)));
    end else if (n != 0) begin
      for (int k = 0; k < n; k++)
        v = (v << 8) | {24'h0, ref_ram[int'((r.addr + 32'(k)) & 32'(MEM_SZ - 1))]};
      if (r.size == 3'd2 && v[15]) v = v | 32'hFFFF0000;
      if (r.size == 3'd3 && v[7])  v = v | 32'hFFFFFF00;
    end
    e.side  = s;
    e.err   = (n == 0);
    e.rdata = r.has_k ? r.k : v;
    e.due   = cyc + ((n == 0) ? 1 : n + 1);
    exp_q.push_back(e);
    $display("[TB] accept side=%0d we=%0d size=%0d addr=%08h wdata=%08h", s, r.we, r.size, r.addr, r.wdata);
  endtask

  task automatic run(input int budget);
    int c;
    int qs;
    logic [1:0] rdy, vld;
    c = 0;
    while (c < budget) begin
      if (q0.size() == 0 && q1.size() == 0 && req_valid == 2'b00 && exp_q.size() == 0 && !busy) break;
      @(negedge clk);
      rdy = req_ready;
      vld = req_valid;
      for (int s = 0; s < 2; s++) if (rdy[s]) model_accept(s, vld == 2'b11);
      @(posedge clk);
      #1;
      c++;
      for (int s = 0; s < 2; s++) begin
        if (rdy[s]) req_valid[s] = 1'b0;
        else if (req_valid[s] && wd_en && $urandom_range(0, 15) == 0) begin
          req_valid[s] = 1'b0;
          $display("[TB] withdraw side=%0d", s);
        end
        qs = (s == 0) ? q0.size() : q1.size();
        if (!req_valid[s] && qs > 0 && (!gap_en || $urandom_range(0, 2) != 0)) begin
          if (s == 0) cur[0] = q0.pop_front(); else cur[1] = q1.pop_front();
          req_we[s]    = cur[s].we;
          req_size[s]  = cur[s].size;
          req_addr[s]  = cur[s].addr;
          req_wdata[s] = cur[s].wdata;
          req_valid[s] = 1'b1;
        end
      end
    end
    if (c >= budget) begin
      tests++;
      fails++;
      $display("FAIL run_timeout: got %0d cycles, required completion within %0d", c, budget);
      q0.delete(); q1.delete();
      req_valid = 2'b00;
    end
  endtask

  // Response monitor, independent of the stimulus process.
  always @(negedge clk) begin
    if (!rst) begin
      if (rsp_valid != 2'b00) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_rsp: got rsp_valid=%b required none", rsp_valid);
        end else begin
          mon_e = exp_q.pop_front();
          chk("rsp_side", {30'h0, rsp_valid}, (mon_e.side == 1) ? 32'h2 : 32'h1);
          chk("rsp_rdata", rsp_rdata, mon_e.rdata);
          chk("rsp_err", {31'h0, rsp_err}, {31'h0, mon_e.err});
          chk("rsp_latency", 32'(cyc), 32'(mon_e.due));
          $display("[TB] rsp side=%0d rdata=%08h err=%0d", mon_e.side, rsp_rdata, rsp_err);
        end
      end
      if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
        tests++;
        fails++;
        $display("FAIL rsp_missing: got no response by cycle %0d, required at %0d", cyc, exp_q[0].due);
        void'(exp_q.pop_front());
      end
      if (!busy) chk("idle_mem_port", {6'h0, mem_we, mem_addr, mem_wdata}, 32'h0);
      else       chk("ready_while_busy", {30'h0, req_ready}, 32'h0);
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got no finish, required finish before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    req_t r;
    logic [16:0] a17;
    rst = 1'b1;
    req_valid = 2'b00; req_we = 2'b00; req_size = '0; req_addr = '0; req_wdata = '0;
    gap_en = 1'b0; wd_en = 1'b0; rr_m = 1'b0;
    for (int i = 0; i < MEM_SZ; i++) begin
      ram[i] <= 8'h00;
      ref_ram[i] = 8'h00;
    end
    for (int i = 0; i < 64; i++) begin
      r.wdata = $urandom;
      ram[32'h100 + i] <= r.wdata[7:0];     ref_ram[32'h100 + i] = r.wdata[7:0];
      ram[32'h1FFC0 + i] <= r.wdata[15:8];  ref_ram[32'h1FFC0 + i] = r.wdata[15:8];
    end
    ram[32'h20] <= 8'h80; ram[32'h21] <= 8'h01; ram[32'h22] <= 8'h7F; ram[32'h23] <= 8'hFF;
    ref_ram[32'h20] = 8'h80; ref_ram[32'h21] = 8'h01; ref_ram[32'h22] = 8'h7F; ref_ram[32'h23] = 8'hFF;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_flags", {25'h0, req_ready, rsp_valid, rsp_err, mem_we, busy}, 32'h0);
    chk("reset_rdata", rsp_rdata, 32'h0);
    chk("reset_mem_addr", {15'h0, mem_addr}, 32'h0);
    chk("reset_mem_wdata", {24'h0, mem_wdata}, 32'h0);
    rst = 1'b0;

    // Round-robin with both requesters continuously asserting.
    push_req(0, 1'b1, 3'b001, 32'h108, 32'hCAFEF00D, 1'b0, 32'h0);
    push_req(0, 1'b0, 3'b001, 32'h108, 32'h0, 1'b1, 32'hCAFEF00D);
    push_req(1, 1'b1, 3'b010, 32'h110, 32'h00001234, 1'b0, 32'h0);
    push_req(1, 1'b0, 3'b100, 32'h110, 32'h0, 1'b1, 32'h00001234);
    run(200);
    chk("rr_grant_count", 32'(grant_log.size()), 32'd4);
    if (grant_log.size() == 4) begin
      chk("rr_grant_0", 32'(grant_log[0]), 32'd0);
      chk("rr_grant_1", 32'(grant_log[1]), 32'd1);
      chk("rr_grant_2", 32'(grant_log[2]), 32'd0);
      chk("rr_grant_3", 32'(grant_log[3]), 32'd1);
    end

    push_req(0, 1'b1, 3'b001, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
    run(100);
    chk("sw_byte_10", {24'h0, ram[32'h10]}, 32'hDE);
    chk("sw_byte_11", {24'h0, ram[32'h11]}, 32'hAD);
    chk("sw_byte_12", {24'h0, ram[32'h12]}, 32'hBE);
    chk("sw_byte_13", {24'h0, ram[32'h13]}, 32'hEF);

    push_req(1, 1'b0, 3'b010, 32'h20, 32'h0, 1'b1, 32'hFFFF8001);
    push_req(1, 1'b0, 3'b100, 32'h20, 32'h0, 1'b1, 32'h00008001);
    push_req(0, 1'b0, 3'b011, 32'h20, 32'h0, 1'b1, 32'hFFFFFF80);
    push_req(0, 1'b0, 3'b101, 32'h20, 32'h0, 1'b1, 32'h00000080);
    push_req(0, 1'b0, 3'b001, 32'h20, 32'h0, 1'b1, 32'h80017FFF);
    run(200);

    push_req(0, 1'b1, 3'b001, 32'h0001FFFE, 32'h11223344, 1'b0, 32'h0);
    run(100);
    chk("wrap_byte_1fffe", {24'h0, ram[32'h1FFFE]}, 32'h11);
    chk("wrap_byte_1ffff", {24'h0, ram[32'h1FFFF]}, 32'h22);
    chk("wrap_byte_00000", {24'h0, ram[32'h0]}, 32'h33);
    chk("wrap_byte_00001", {24'h0, ram[32'h1]}, 32'h44);

    push_req(1, 1'b1, 3'b111, 32'h30, 32'hFFFFFFFF, 1'b0, 32'h0);
    push_req(0, 1'b0, 3'b000, 32'h30, 32'h0, 1'b0, 32'h0);
    run(100);
    chk("invalid_no_write", {24'h0, ram[32'h30]}, 32'h0);

    gap_en = 1'b1;
    wd_en  = 1'b1;
    for (int i = 0; i < 80; i++) begin
      a17 = ($urandom_range(0, 1) == 1) ? 17'(32'h100 + $urandom_range(0, 60)) : 17'(32'h1FFF8 + $urandom_range(0, 7));
      r.addr = {15'($urandom), a17};
      push_req(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
               r.addr, $urandom, 1'b0, 32'h0);
    end
    run(5000);
    gap_en = 1'b0;
    wd_en  = 1'b0;

    // Reset during the third byte of a word store.
    @(posedge clk);
    #1;
    req_we[0] = 1'b1; req_size[0] = 3'b001; req_addr[0] = 32'h40; req_wdata[0] = 32'hA1B2C3D4;
    req_valid = 2'b01;
    begin
      int w;
      w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (!req_ready[0] && w < 20);
      if (!req_ready[0]) begin
        tests++;
        fails++;
        $display("FAIL abort_accept_timeout: got no req_ready, required within 20 cycles");
      end
    end
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_mem_we", {31'h0, mem_we}, 32'h0);
    chk("abort_busy", {31'h0, busy}, 32'h0);
    ref_ram[32'h40] = 8'hA1;
    ref_ram[32'h41] = 8'hB2;
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_rsp", {30'h0, rsp_valid}, 32'h0);
    end
    @(posedge clk);
    #1;
    rst  = 1'b0;
    rr_m = 1'b0;
    chk("abort_byte_42", {24'h0, ram[32'h42]}, 32'h0);
    push_req(1, 1'b0, 3'b001, 32'h40, 32'h0, 1'b1, 32'hA1B20000);
    run(100);

    begin
      int bad;
      bad = 0;
      for (int i = 0; i < 512; i++) begin
        if (ram[i] !== ref_ram[i] && bad == 0) begin
          bad = 1;
          $display("FAIL ram_low_region: at %05h got %02h expected %02h", i, ram[i], ref_ram[i]);
        end
        if (ram[MEM_SZ - 256 + i / 2] !== ref_ram[MEM_SZ - 256 + i / 2] && bad == 0) begin
          bad = 1;
          $display("FAIL ram_high_region: at %05h got %02h expected %02h", MEM_SZ - 256 + i / 2,
                   ram[MEM_SZ - 256 + i / 2], ref_ram[MEM_SZ - 256 + i / 2]);
        end
      end
      tests++;
      if (bad != 0) fails++;
    end
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
